// File: rtl/clock_pkg.sv
// clock_pkg: field encoding, FSM states, limits and wrap helper shared by the time-set logic
package clock_pkg;
  localparam int HRS_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam logic [5:0] HRS_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;
  typedef enum logic [1:0] {FIELD_NONE, FIELD_HRS, FIELD_MIN, FIELD_SEC} field_e;
  typedef enum logic [2:0] {IDLE, EDIT_HRS, EDIT_MIN, EDIT_SEC, COMMIT} state_e;
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                           input logic up, input logic dn);
    return up ? (v == max ? 6'd0 : v + 6'd1) : dn ? (v == 6'd0 ? max : v - 6'd1) : v;
  endfunction
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: debounced button inputs plus committed/working time outputs
//   master: drives set_en/btn_*, observes set_*/edit_*/field_o/load_o
//   slave:  the controller side
interface time_set_ctrl_if;
  import clock_pkg::*;
  logic             set_en;
  logic             btn_next;
  logic             btn_inc;
  logic             btn_dec;
  logic [HRS_W-1:0] set_hrs;
  logic [MIN_W-1:0] set_min;
  logic [SEC_W-1:0] set_sec;
  logic [HRS_W-1:0] edit_hrs;
  logic [MIN_W-1:0] edit_min;
  logic [SEC_W-1:0] edit_sec;
  logic [1:0]       field_o;
  logic             load_o;
  modport master (output set_en, btn_next, btn_inc, btn_dec,
                  input  set_hrs, set_min, set_sec, edit_hrs, edit_min, edit_sec, field_o, load_o);
  modport slave  (input  set_en, btn_next, btn_inc, btn_dec,
                  output set_hrs, set_min, set_sec, edit_hrs, edit_min, edit_sec, field_o, load_o);
endinterface

// File: rtl/btn_step_gen.sv
// btn_step_gen: registered rising-edge detect with optional hold-to-repeat, one-cycle step_o
//   clk_i, reset_i (async active-low), btn_i debounced level, step_o step pulse (combinational
//   from btn_i so the press acts on the same clock edge that samples it)
//   TIME_SET_AUTO_REPEAT_EN: adds HOLD_CYC/RPT_CYC repeat counter, enabled per instance by RPT_EN
module btn_step_gen
`ifdef TIME_SET_AUTO_REPEAT_EN
  #(parameter int HOLD_CYC = 500, parameter int RPT_CYC = 100, parameter bit RPT_EN = 1'b0)
`endif
  (input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic step_o);
  logic btn_q;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int CW = $clog2((HOLD_CYC > RPT_CYC ? HOLD_CYC : RPT_CYC) + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt;
  // cnt_q holds the cycles left until the next repeat step while the button stays held
  always_comb begin
    rpt    = RPT_EN && btn_i && btn_q && cnt_q == '0;
    cnt_d  = (!RPT_EN || !btn_i) ? '0 : !btn_q ? CW'(HOLD_CYC - 1) : rpt ? CW'(RPT_CYC - 1) : cnt_q - CW'(1);
    step_o = (btn_i & ~btn_q) | rpt;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_i;
      cnt_q <= cnt_d;
    end
`else
  assign step_o = btn_i & ~btn_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) btn_q <= 1'b0;
    else btn_q <= btn_i;
`endif
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hours/minutes/seconds entry feeding the clock blocks' presets
//   clk_i 1 kHz clock, reset_i async active-low, bus (slave): set_en/btn_next/btn_inc/btn_dec in,
//   set_* committed time, edit_* working time, field_o edited field, load_o commit pulse
//   TIME_SET_AUTO_REPEAT_EN: hold inc/dec to auto-repeat after HOLD_CYC, then every RPT_CYC
module time_set_ctrl
  import clock_pkg::*;
  #(parameter int RST_HRS  = 17,
    parameter int RST_MIN  = 35,
    parameter int RST_SEC  = 42,
    parameter int HOLD_CYC = 500,
    parameter int RPT_CYC  = 100)
  (input  logic              clk_i,
   input  logic              reset_i,
   time_set_ctrl_if.slave    bus);
  if (RST_HRS > 23 || RST_MIN > 59 || RST_SEC > 59 || HOLD_CYC < 1 || RPT_CYC < 1) begin : g_bad_param
    $error("time_set_ctrl: parameter out of range");
  end
  logic en_rise, nx_rise, inc_step, dec_step, up, dn;
  state_e           state_q, state_d;
  field_e           field_q, field_d;
  logic             load_q, load_d;
  logic [HRS_W-1:0] set_hrs_q, set_hrs_d, edit_hrs_q, edit_hrs_d, hrs_step;
  logic [MIN_W-1:0] set_min_q, set_min_d, edit_min_q, edit_min_d, min_step;
  logic [SEC_W-1:0] set_sec_q, set_sec_d, edit_sec_q, edit_sec_d, sec_step;
  btn_step_gen u_set  (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.set_en),   .step_o(en_rise));
  btn_step_gen u_next (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.btn_next), .step_o(nx_rise));
`ifdef TIME_SET_AUTO_REPEAT_EN
  btn_step_gen #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .RPT_EN(1'b1))
    u_inc (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.btn_inc), .step_o(inc_step));
  btn_step_gen #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .RPT_EN(1'b1))
    u_dec (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.btn_dec), .step_o(dec_step));
`else
  btn_step_gen u_inc (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.btn_inc), .step_o(inc_step));
  btn_step_gen u_dec (.clk_i(clk_i), .reset_i(reset_i), .btn_i(bus.btn_dec), .step_o(dec_step));
`endif
  assign up       = inc_step & ~dec_step;
  assign dn       = dec_step & ~inc_step;
  assign hrs_step = HRS_W'(wrap_step(6'(edit_hrs_q), HRS_MAX, up, dn));
  assign min_step = wrap_step(edit_min_q, MIN_MAX, up, dn);
  assign sec_step = wrap_step(edit_sec_q, SEC_MAX, up, dn);
  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    set_hrs_d  = set_hrs_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    edit_hrs_d = edit_hrs_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    case (state_q)
      IDLE: if (en_rise) begin
        state_d    = EDIT_HRS;
        edit_hrs_d = set_hrs_q;
        edit_min_d = set_min_q;
        edit_sec_d = set_sec_q;
      end
      EDIT_HRS, EDIT_MIN, EDIT_SEC: if (!bus.set_en) begin
        state_d    = IDLE;
        edit_hrs_d = set_hrs_q;
        edit_min_d = set_min_q;
        edit_sec_d = set_sec_q;
      end else begin
        edit_hrs_d = state_q == EDIT_HRS ? hrs_step : edit_hrs_q;
        edit_min_d = state_q == EDIT_MIN ? min_step : edit_min_q;
        edit_sec_d = state_q == EDIT_SEC ? sec_step : edit_sec_q;
        if (nx_rise) begin
          state_d = state_q == EDIT_HRS ? EDIT_MIN : state_q == EDIT_MIN ? EDIT_SEC : COMMIT;
          // commit while entering COMMIT so set_* and load_o appear together in the COMMIT cycle
          if (state_q == EDIT_SEC) begin
            set_hrs_d = edit_hrs_d;
            set_min_d = edit_min_d;
            set_sec_d = edit_sec_d;
            load_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    field_d = state_d == EDIT_HRS ? FIELD_HRS : state_d == EDIT_MIN ? FIELD_MIN :
              state_d == EDIT_SEC ? FIELD_SEC : FIELD_NONE;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q    <= IDLE;
      field_q    <= FIELD_NONE;
      load_q     <= 1'b0;
      set_hrs_q  <= HRS_W'(RST_HRS);
      set_min_q  <= MIN_W'(RST_MIN);
      set_sec_q  <= SEC_W'(RST_SEC);
      edit_hrs_q <= HRS_W'(RST_HRS);
      edit_min_q <= MIN_W'(RST_MIN);
      edit_sec_q <= SEC_W'(RST_SEC);
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      load_q     <= load_d;
      set_hrs_q  <= set_hrs_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      edit_hrs_q <= edit_hrs_d;
      edit_min_q <= edit_min_d;
      edit_sec_q <= edit_sec_d;
    end
  assign bus.set_hrs  = set_hrs_q;
  assign bus.set_min  = set_min_q;
  assign bus.set_sec  = set_sec_q;
  assign bus.edit_hrs = edit_hrs_q;
  assign bus.edit_min = edit_min_q;
  assign bus.edit_sec = edit_sec_q;
  assign bus.field_o  = field_q;
  assign bus.load_o   = load_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random button stimulus against a time-arithmetic reference model
module tb_time_set_ctrl;
  localparam int H = 500;
  localparam int R = 100;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  time_set_ctrl_if bus();
  time_set_ctrl #(.RST_HRS(17), .RST_MIN(35), .RST_SEC(42), .HOLD_CYC(H), .RPT_CYC(R))
    dut (.clk_i(clk), .reset_i(rst_n), .bus(bus));
  int checks = 0, errors = 0, loads = 0;
  int c[3], e[3], mode, age_in, age_dc;
  int lim[3] = '{24, 60, 60};
  bit m_load, p_en, p_nx, p_in, p_dc;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] dut_vec();
    return 64'({bus.set_hrs, bus.set_min, bus.set_sec, bus.edit_hrs, bus.edit_min, bus.edit_sec,
                bus.field_o, bus.load_o});
  endfunction
  function automatic logic [63:0] model_vec();
    return 64'({5'(c[0]), 6'(c[1]), 6'(c[2]), 5'(e[0]), 6'(e[1]), 6'(e[2]),
                2'((mode >= 1 && mode <= 3) ? mode : 0), m_load});
  endfunction
  function automatic bit rpt_due(input int age);
    return AR && age >= H && (age - H) % R == 0;
  endfunction
  task automatic model_reset();
    c = '{17, 35, 42};
    e = c;
    mode = 0;
    m_load = 0;
    {p_en, p_nx, p_in, p_dc} = 4'b0;
    age_in = -1;
    age_dc = -1;
  endtask
  // one clock edge of the reference: mode 0 idle, 1..3 editing field mode-1, 4 commit
  task automatic model_clock();
    bit en_r, nx_r, si, sd;
    int d;
    en_r   = bus.set_en && !p_en;
    nx_r   = bus.btn_next && !p_nx;
    age_in = bus.btn_inc ? (p_in ? age_in + 1 : 0) : -1;
    age_dc = bus.btn_dec ? (p_dc ? age_dc + 1 : 0) : -1;
    si     = bus.btn_inc && (age_in == 0 || rpt_due(age_in));
    sd     = bus.btn_dec && (age_dc == 0 || rpt_due(age_dc));
    d      = int'(si) - int'(sd);
    m_load = 0;
    if (mode == 0) begin
      if (en_r) begin e = c; mode = 1; end
    end else if (mode <= 3) begin
      if (!bus.set_en) begin
        mode = 0;
        e = c;
      end else begin
        e[mode-1] = (e[mode-1] + d + lim[mode-1]) % lim[mode-1];
        if (nx_r) begin
          if (mode == 3) begin c = e; m_load = 1; mode = 4; end
          else mode++;
        end
      end
    end else mode = 0;
    {p_en, p_nx, p_in, p_dc} = {bus.set_en, bus.btn_next, bus.btn_inc, bus.btn_dec};
  endtask
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    if (bus.load_o) loads++;
    check_eq("cyc", dut_vec(), model_vec());
  endtask
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_inc = v;
      1: bus.btn_dec = v;
      default: bus.btn_next = v;
    endcase
  endtask
  task automatic pulse(input int which, input int n);
    repeat (n) begin
      set_btn(which, 1'b1);
      tick();
      set_btn(which, 1'b0);
      tick();
    end
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_eq(tag, dut_vec(), model_vec());
    @(negedge clk) rst_n = 1'b0;
    rst_n = 1'b1;
  endtask
  initial begin
    logic [5:0] keep;
    {bus.set_en, bus.btn_next, bus.btn_inc, bus.btn_dec} = 4'b0;
    model_reset();
    #12;
    check_eq("rst_vec", dut_vec(), model_vec());
    check_eq("rst_set", 64'({bus.set_hrs, bus.set_min, bus.set_sec}), 64'({5'd17, 6'd35, 6'd42}));
    @(negedge clk) rst_n = 1'b1;
    // edit hours to 5 then abort
    bus.set_en = 1'b1;
    tick();
    check_eq("field_hrs", 64'(bus.field_o), 64'd1);
    pulse(0, 12);
    check_eq("abort_edit5", 64'(bus.edit_hrs), 64'd5);
    bus.set_en = 1'b0;
    tick();
    check_eq("abort_set", 64'({bus.set_hrs, bus.set_min, bus.set_sec}), 64'({5'd17, 6'd35, 6'd42}));
    check_eq("abort_edit", 64'(bus.edit_hrs), 64'd17);
    check_eq("abort_noload", 64'(loads), 64'd0);
    // full commit 20:33:42
    bus.set_en = 1'b1;
    tick();
    pulse(0, 3);
    pulse(2, 1);
    pulse(1, 2);
    pulse(2, 2);
    check_eq("commit_set", 64'({bus.set_hrs, bus.set_min, bus.set_sec}), 64'({5'd20, 6'd33, 6'd42}));
    check_eq("commit_loads", 64'(loads), 64'd1);
    bus.set_en = 1'b0;
    tick();
    // wrap boundaries
    bus.set_en = 1'b1;
    tick();
    pulse(0, 4);
    check_eq("hrs_wrap", 64'(bus.edit_hrs), 64'd0);
    pulse(2, 1);
    pulse(0, 27);
    check_eq("min_wrap", 64'(bus.edit_min), 64'd0);
    pulse(2, 1);
    pulse(1, 43);
    check_eq("sec_wrap", 64'(bus.edit_sec), 64'd59);
    bus.set_en = 1'b0;
    tick();
    // hold inc for 800 cycles on minutes
    async_reset("rst_before_hold");
    bus.set_en = 1'b1;
    tick();
    pulse(2, 1);
    bus.btn_inc = 1'b1;
    repeat (800) tick();
    bus.btn_inc = 1'b0;
    tick();
    check_eq("hold_rpt", 64'(bus.edit_min), AR ? 64'd39 : 64'd36);
    // simultaneous inc and dec
    keep = bus.edit_min;
    {bus.btn_inc, bus.btn_dec} = 2'b11;
    tick();
    check_eq("inc_dec_same", 64'(bus.edit_min), 64'(keep));
    {bus.btn_inc, bus.btn_dec} = 2'b00;
    tick();
    check_eq("field_min", 64'(bus.field_o), 64'd2);
    async_reset("rst_mid_edit");
    check_eq("rst_mid_field", 64'(bus.field_o), 64'd0);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) bus.set_en = ~bus.set_en;
      if ($urandom_range(3) == 0) bus.btn_inc = ~bus.btn_inc;
      if ($urandom_range(3) == 0) bus.btn_dec = ~bus.btn_dec;
      if ($urandom_range(5) == 0) bus.btn_next = ~bus.btn_next;
      if ($urandom_range(999) == 0) async_reset("rst_rand");
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
